seq_slice_adder32: RTL and testbench

//   Multi-cycle two's-complement adder: S = A + B + Cin, computed SLICE bits per clock

---
 rtl/seq_slice_adder32.sv | 116 +++++++++++
 tb/tb_seq_slice_adder32.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_slice_adder32.sv
// Multi-cycle ripple adder: S = A + B + Cin, SLICE bits per clock.
// Carry rides between slices in a register; Cr/V follow the add convention.
module seq_slice_adder32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cr,
  output logic             V
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] sum_s;
  logic [SLICE:0]   c;
  logic             last;
  logic             accept;

  // One slice of the ripple chain; c[SLICE-1] is the carry into the MSB.
  always_comb begin
    a_s  = a_q[idx*SLICE +: SLICE];
    b_s  = b_q[idx*SLICE +: SLICE];
    c    = '0;
    sum_s = '0;
    c[0] = carry;
    for (int i = 0; i < SLICE; i++) begin
      sum_s[i] = a_s[i] ^ b_s[i] ^ c[i];
      c[i+1]   = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
    end
    last = (idx == IW'(N - 1));
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      S     <= '0;
      Cr    <= 1'b0;
      V     <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      carry <= Cin;
      idx   <= '0;
      S     <= '0;
      Cr    <= 1'b0;
      V     <= 1'b0;
    end else if (state == RUN) begin
      S[idx*SLICE +: SLICE] <= sum_s;
      carry <= c[SLICE];
      idx   <= idx + 1'b1;
      if (last) begin
        Cr <= c[SLICE];
        V  <= c[SLICE] ^ c[SLICE-1];
      end
    end
  end

endmodule

// File: tb/tb_seq_slice_adder32.sv
// Scoreboard bench for seq_slice_adder32.
// Expected results come from plain 33-bit addition and sign rules.
module tb_seq_slice_adder32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        busy;
  logic        done;
  logic [31:0] S;
  logic        Cr;
  logic        V;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  seq_slice_adder32 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .busy (busy),
    .done (done),
    .S    (S),
    .Cr   (Cr),
    .V    (V)
  );

  function automatic logic [33:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic c);
    logic [32:0] t;
    logic        ov;
    t  = {1'b0, a} + {1'b0, b} + {32'd0, c};
    ov = (a[31] == b[31]) && (t[31] != a[31]);
    return {t[32], ov, t[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [33:0] got,
                     input logic [33:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 34'd1, 34'd0);
      end else begin
        chk("result", {Cr, V, S}, exp_q.pop_front());
      end
    end
  end

  // Waits for busy==0, then presents one op for a single edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic c, input bit scored);
    int n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("busy_timeout", 34'd1, 34'd0);
    A = a; B = b; Cin = c; start = 1'b1;
    if (scored) exp_q.push_back(model(a, b, c));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 34'(exp_q.size()), 34'd0);
  endtask

  initial begin
    int lat;
    int bcnt;
    int d0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, Cr, V, S}, 36'd0);
    rst = 1'b0;

    // Directed cases, latency on the first one.
    issue(32'h1, 32'h1, 1'b0, 1'b1);
    lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 34'(lat), 34'd4);
    chk("busy_in_done", {33'd0, busy}, 34'd0);
    @(posedge clk); #1;
    chk("s_hold", {2'b0, S}, 34'h2);
    issue(32'hFFFFFFFF, 32'h1, 1'b0, 1'b1);
    issue(32'h7FFFFFFF, 32'h1, 1'b0, 1'b1);
    issue(32'h80000000, 32'h80000000, 1'b0, 1'b1);
    issue(32'h0000FFFF, 32'h0, 1'b1, 1'b1);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    issue(32'h00FF00FF, 32'h00010001, 1'b0, 1'b1);
    drain();

    // start held through RUN while operands change.
    repeat (3) @(posedge clk);
    #1;
    d0 = n_done;
    A = 32'h12345678; B = 32'h0F0F0F0F; Cin = 1'b1; start = 1'b1;
    exp_q.push_back(model(32'h12345678, 32'h0F0F0F0F, 1'b1));
    @(posedge clk); #1;
    bcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) bcnt++;
      A = $urandom; B = $urandom; Cin = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_cycles", 34'(bcnt), 34'd4);
    repeat (6) @(posedge clk);
    #1;
    chk("single_done", 34'(n_done - d0), 34'd1);
    drain();

    // Reset sampled at E2 of an op.
    issue(32'hDEADBEEF, 32'hCAFEBABE, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset", {busy, done, Cr, V, S}, 36'd0);
    rst = 1'b0;
    issue(32'h89ABCDEF, 32'h76543210, 1'b1, 1'b1);
    drain();

    // Random sweep; issue() starts each op in the DONE cycle of the last.
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (k % 7 == 0) rb = ~ra;
      issue(ra, rb, 1'($urandom), 1'b1);
      if ($urandom_range(0, 9) == 0) begin
        while (busy) begin
          @(posedge clk); #1;
        end
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
